// File: rtl/audio_pkg.sv
// Shared constants and helpers for the DE1-SoC audio DAC path.
package audio_pkg;

   localparam logic FMT_I2S = 1'b0;
   localparam logic FMT_LJ  = 1'b1;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Stereo sample-pair stream from the audio generator into the I2S transmitter.
interface audio_i2s_tx_if #(
   parameter int unsigned SAMPLE_W = 24
);

   logic                s_valid;
   logic                s_ready;
   logic [SAMPLE_W-1:0] s_left;
   logic [SAMPLE_W-1:0] s_right;

   modport master (output s_valid, output s_left, output s_right, input s_ready);
   modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO of packed {left, right} sample pairs; depth must be a power of two.
module audio_sample_fifo
   import audio_pkg::*;
#(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      pop_data,
   output logic                  full,
   output logic                  empty,
   output logic [clog2(DEPTH):0] level
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      level_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (level_q == FULL_LEVEL);
   assign empty    = (level_q == '0);
   assign level    = level_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop) begin
            level_q <= level_q + 1'b1;
         end else if (do_pop && !do_push) begin
            level_q <= level_q - 1'b1;
         end
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S / left-justified DAC serializer slaved to codec bclk/lrck, fed from a sample-pair FIFO.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int unsigned SAMPLE_W   = 24,
   parameter int unsigned SLOT_W     = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fmt,
   audio_i2s_tx_if.slave              s,
   input  logic                       bclk,
   input  logic                       lrck,
   output logic                       dacdat,
   output logic [clog2(FIFO_DEPTH):0] fifo_level,
   output logic                       underrun
);

   localparam int unsigned   PW    = clog2(SLOT_W);
   localparam logic [PW-1:0] P_MAX = PW'(SLOT_W - 1);

   logic                  bclk_s1_q, bclk_s2_q, bclk_h_q;
   logic                  lrck_s1_q, lrck_s2_q;
   logic                  lrck_prev_q, lrck_prev_d;
   logic [PW-1:0]         p_q, p_d;
   logic                  fmt_q, fmt_d;
   logic [SAMPLE_W-1:0]   shadow_l_q, shadow_l_d;
   logic [SAMPLE_W-1:0]   shadow_r_q, shadow_r_d;
   logic [SAMPLE_W-1:0]   shadow_sel;
   logic [SAMPLE_W-1:0]   shadow_shift;
   logic                  dacdat_q, dacdat_d;
   logic                  bfall, chan_start, frame_start;
   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [2*SAMPLE_W-1:0] fifo_rdata;
   int                    k;

   assign s.s_ready = ~fifo_full;
   assign fifo_push = s.s_valid & ~fifo_full;
   assign dacdat    = dacdat_q;

   audio_sample_fifo #(
      .WIDTH (2 * SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data ({s.s_left, s.s_right}),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_comb begin
      bfall       = bclk_h_q & ~bclk_s2_q & ~reset;
      chan_start  = bfall & (lrck_s2_q != lrck_prev_q);
      frame_start = chan_start & ~lrck_s2_q;
      // A same-cycle push into an empty FIFO never bypasses; that frame underruns.
      fifo_pop    = frame_start & ~fifo_empty;
      underrun    = frame_start & fifo_empty;

      p_d         = p_q;
      lrck_prev_d = lrck_prev_q;
      if (chan_start) begin
         p_d         = '0;
         lrck_prev_d = lrck_s2_q;
      end else if (bfall && (p_q != P_MAX)) begin
         p_d = p_q + 1'b1;
      end

      fmt_d      = fmt_q;
      shadow_l_d = shadow_l_q;
      shadow_r_d = shadow_r_q;
      if (frame_start) begin
         fmt_d      = fmt;
         shadow_l_d = fifo_pop ? fifo_rdata[2*SAMPLE_W-1 -: SAMPLE_W] : '0;
         shadow_r_d = fifo_pop ? fifo_rdata[SAMPLE_W-1:0] : '0;
      end

      // k is the sample bit index for this bclk; outside [0, SAMPLE_W) the line pads with 0.
      k            = int'(p_d) - ((fmt_d == FMT_I2S) ? 1 : 0);
      shadow_sel   = lrck_prev_d ? shadow_r_d : shadow_l_d;
      shadow_shift = shadow_sel << k;
      dacdat_d     = dacdat_q;
      if (bfall) begin
         dacdat_d = ((k >= 0) && (k < int'(SAMPLE_W))) ? shadow_shift[SAMPLE_W-1] : 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bclk_s1_q   <= 1'b0;
         bclk_s2_q   <= 1'b0;
         bclk_h_q    <= 1'b0;
         lrck_s1_q   <= 1'b0;
         lrck_s2_q   <= 1'b0;
         lrck_prev_q <= 1'b0;
         p_q         <= '0;
         fmt_q       <= FMT_I2S;
         shadow_l_q  <= '0;
         shadow_r_q  <= '0;
         dacdat_q    <= 1'b0;
      end else begin
         bclk_s1_q   <= bclk;
         bclk_s2_q   <= bclk_s1_q;
         bclk_h_q    <= bclk_s2_q;
         lrck_s1_q   <= lrck;
         lrck_s2_q   <= lrck_s1_q;
         lrck_prev_q <= lrck_prev_d;
         p_q         <= p_d;
         fmt_q       <= fmt_d;
         shadow_l_q  <= shadow_l_d;
         shadow_r_q  <= shadow_r_d;
         dacdat_q    <= dacdat_d;
      end
   end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Randomised bench for audio_i2s_tx: 24-bit and 16-bit instances against a queue-based frame model.
module tb_audio_i2s_tx;
   import audio_pkg::*;

   localparam int unsigned SLOT_W     = 32;
   localparam int unsigned FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset, fmt, bclk, lrck;
   logic       dacdat24, dacdat16, underrun24, underrun16;
   logic [2:0] level24, level16;

   logic [47:0] mq[$];
   logic [47:0] cur;
   logic        cur_f;
   int          exp_ur = 0;
   int          ur24 = 0;
   int          ur16 = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   audio_i2s_tx_if #(.SAMPLE_W(24)) s24 ();
   audio_i2s_tx_if #(.SAMPLE_W(16)) s16 ();

   assign s16.s_valid = s24.s_valid;
   assign s16.s_left  = s24.s_left[15:0];
   assign s16.s_right = s24.s_right[15:0];

   audio_i2s_tx #(.SAMPLE_W(24), .SLOT_W(SLOT_W), .FIFO_DEPTH(FIFO_DEPTH)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .fmt        (fmt),
      .s          (s24),
      .bclk       (bclk),
      .lrck       (lrck),
      .dacdat     (dacdat24),
      .fifo_level (level24),
      .underrun   (underrun24)
   );

   audio_i2s_tx #(.SAMPLE_W(16), .SLOT_W(SLOT_W), .FIFO_DEPTH(FIFO_DEPTH)) u_dut16 (
      .clk        (clk),
      .reset      (reset),
      .fmt        (fmt),
      .s          (s16),
      .bclk       (bclk),
      .lrck       (lrck),
      .dacdat     (dacdat16),
      .fifo_level (level16),
      .underrun   (underrun16)
   );

   always @(negedge clk) begin
      if (underrun24 === 1'b1) ur24++;
      if (underrun16 === 1'b1) ur16++;
   end

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Serial bit expected on the j-th bclk fall of a channel slot.
   function automatic logic exp_bit(input logic [23:0] smp, input int w, input int j,
                                    input logic f);
      int          p, kk;
      logic [23:0] t;
      p  = (j > int'(SLOT_W) - 1) ? int'(SLOT_W) - 1 : j;
      kk = p - ((f == FMT_I2S) ? 1 : 0);
      if (kk < 0 || kk >= w) return 1'b0;
      t = smp >> (w - 1 - kk);
      return t[0];
   endfunction

   task automatic push_cycle(input logic [23:0] l, input logic [23:0] r);
      check("s_ready24", 48'(s24.s_ready), 48'(mq.size() < FIFO_DEPTH));
      check("s_ready16", 48'(s16.s_ready), 48'(mq.size() < FIFO_DEPTH));
      s24.s_valid = 1'b1;
      s24.s_left  = l;
      s24.s_right = r;
      if (mq.size() < FIFO_DEPTH) mq.push_back({l, r});
      @(posedge clk);
      #1;
      s24.s_valid = 1'b0;
      check("fifo_level24", 48'(level24), 48'(mq.size()));
      check("fifo_level16", 48'(level16), 48'(mq.size()));
   endtask

   task automatic do_reset();
      s24.s_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      mq.delete();
      cur = '0;
      check("rst_level24", 48'(level24), 48'(0));
      check("rst_level16", 48'(level16), 48'(0));
      check("rst_ready24", 48'(s24.s_ready), 48'(1));
      check("rst_dacdat24", 48'(dacdat24), 48'(0));
      check("rst_dacdat16", 48'(dacdat16), 48'(0));
   endtask

   // One bclk period: fall (with lrck update), optional push in the bfall cycle, sample, rise.
   task automatic bclk_cycle(input logic lr, input bit do_push, input logic [47:0] pd,
                             output logic o24, output logic o16);
      repeat (7) @(posedge clk);
      #1;
      bclk = 1'b0;
      lrck = lr;
      repeat (2) @(posedge clk);
      #1;
      if (do_push) begin
         s24.s_valid = 1'b1;
         s24.s_left  = pd[47:24];
         s24.s_right = pd[23:0];
      end
      @(posedge clk);
      #1;
      s24.s_valid = 1'b0;
      o24 = dacdat24;
      o16 = dacdat16;
      repeat (4) @(posedge clk);
      #1;
      bclk = 1'b1;
   endtask

   task automatic run_frame(input int slot, input logic f, input int rst_at,
                            input bit push_start, input logic [47:0] pdata);
      logic o24, o16;
      fmt = f;
      for (int ch = 0; ch < 2; ch++) begin
         for (int j = 0; j < slot; j++) begin
            bit first;
            first = (ch == 0) && (j == 0);
            if (first) begin
               cur_f = f;
               if (mq.size() > 0) begin
                  cur = mq.pop_front();
               end else begin
                  cur = '0;
                  exp_ur++;
               end
            end
            bclk_cycle(ch[0], first && push_start, pdata, o24, o16);
            if (first && push_start && mq.size() < FIFO_DEPTH) mq.push_back(pdata);
            if (first) fmt = 1'($urandom_range(0, 1));
            check("dacdat24", 48'(o24),
                  48'(exp_bit((ch == 0) ? cur[47:24] : cur[23:0], 24, j, cur_f)));
            check("dacdat16", 48'(o16),
                  48'(exp_bit((ch == 0) ? {8'h0, cur[39:24]} : {8'h0, cur[15:0]}, 16, j, cur_f)));
            if (ch == 0 && j == rst_at) do_reset();
         end
      end
      check("underrun_cnt24", 48'(ur24), 48'(exp_ur));
      check("underrun_cnt16", 48'(ur16), 48'(exp_ur));
      check("frame_level24", 48'(level24), 48'(mq.size()));
      check("frame_level16", 48'(level16), 48'(mq.size()));
   endtask

   initial begin
      logic o24, o16;
      reset       = 1'b1;
      fmt         = FMT_I2S;
      bclk        = 1'b1;
      lrck        = 1'b1;
      s24.s_valid = 1'b0;
      s24.s_left  = '0;
      s24.s_right = '0;
      cur         = '0;
      cur_f       = FMT_I2S;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("init_dacdat24", 48'(dacdat24), 48'(0));
      check("init_underrun24", 48'(underrun24), 48'(0));
      check("init_level24", 48'(level24), 48'(0));
      check("init_ready24", 48'(s24.s_ready), 48'(1));
      check("init_level16", 48'(level16), 48'(0));

      // Right-slot lead-in before the first left start carries zeros.
      for (int i = 0; i < 3; i++) begin
         bclk_cycle(1'b1, 1'b0, '0, o24, o16);
         check("prime_dacdat24", 48'(o24), 48'(0));
      end

      // Basic I2S, left-justified, 16-bit width, slow lrck saturation.
      push_cycle(24'hA5F00F, 24'h5A0FF0);
      run_frame(32, FMT_I2S, -1, 1'b0, '0);
      push_cycle(24'hA5F00F, 24'h5A0FF0);
      run_frame(32, FMT_LJ, -1, 1'b0, '0);
      push_cycle(24'h7E8001, 24'h123456);
      run_frame(32, FMT_I2S, -1, 1'b0, '0);
      push_cycle(24'hFFFFFF, 24'h800001);
      run_frame(40, FMT_LJ, -1, 1'b0, '0);

      // Underrun, single pair, underrun again, then no-bypass push at frame start.
      run_frame(32, FMT_I2S, -1, 1'b0, '0);
      run_frame(32, FMT_LJ, -1, 1'b0, '0);
      push_cycle(24'hC3C3C3, 24'h3C3C3C);
      run_frame(32, FMT_I2S, -1, 1'b0, '0);
      run_frame(32, FMT_I2S, -1, 1'b0, '0);
      run_frame(32, FMT_I2S, -1, 1'b1, {24'h9ABCDE, 24'hF01234});
      run_frame(32, FMT_I2S, -1, 1'b0, '0);

      // Backpressure: five back-to-back pushes into a depth-4 FIFO.
      for (int i = 0; i < 5; i++) push_cycle(24'($urandom), 24'($urandom));
      run_frame(32, FMT_LJ, -1, 1'b0, '0);
      push_cycle(24'($urandom), 24'($urandom));

      for (int n = 0; n < 12; n++) begin
         int pushes;
         pushes = $urandom_range(0, 2);
         for (int i = 0; i < pushes; i++) push_cycle(24'($urandom), 24'($urandom));
         run_frame($urandom_range(20, 40), 1'($urandom_range(0, 1)), -1, 1'b0, '0);
      end

      // Reset midway through the left slot with two pairs queued.
      while (mq.size() < 2) push_cycle(24'($urandom), 24'($urandom));
      run_frame(32, FMT_I2S, 10, 1'b0, '0);
      run_frame(32, FMT_I2S, -1, 1'b0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
